// File: rtl/gru_seq_feeder.sv
// Ping-pong sequence buffer feeding the GRU cell one timestep per STEP_CYCLES cycles.
// Optional GRU_FEED_HOLD_EN: x_t holds its last vector while idle instead of zeroing.
module gru_seq_feeder #(
    parameter int X_SIZE      = 6,
    parameter int SEQ_LEN     = 15,
    parameter int WIDTH       = 16,
    parameter int STEP_CYCLES = 19
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [X_SIZE*WIDTH-1:0]   in_data,
    output logic [X_SIZE*WIDTH-1:0]   x_t,
    output logic                      x_valid,
    output logic                      seq_first,
    output logic                      seq_last,
    output logic                      seq_done
);

    localparam int VEC_W  = X_SIZE * WIDTH;
    localparam int IDX_W  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int HOLD_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int ADDR_W = $clog2(2 * SEQ_LEN);
    localparam logic [IDX_W-1:0]  LAST_STEP = IDX_W'(SEQ_LEN - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(STEP_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

    // Bank b occupies entries [b*SEQ_LEN, b*SEQ_LEN + SEQ_LEN - 1]
    logic [VEC_W-1:0] mem [0:2*SEQ_LEN-1];

    state_e            state_q, state_d;
    logic [1:0]        full_q, full_d;
    logic              wb_q, wb_d;
    logic              rb_q, rb_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]  step_q, step_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [VEC_W-1:0]  x_t_q, x_t_d;
    logic              x_valid_q, x_valid_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic              done_pre_q, done_pre_d;
    logic              done_q, done_d;

    logic              accept;
    logic              play_end;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    assign in_ready = !full_q[wb_q];
    assign accept   = in_valid && in_ready;
    assign play_end = (state_q == PLAY) && (step_q == LAST_STEP) && (hold_q == LAST_HOLD);
    assign wr_addr  = wb_q ? (ADDR_W'(SEQ_LEN) + ADDR_W'(wr_idx_q)) : ADDR_W'(wr_idx_q);
    assign rd_addr  = rb_q ? (ADDR_W'(SEQ_LEN) + ADDR_W'(step_q)) : ADDR_W'(step_q);

    // Loader and full flags; set and clear always target different banks
    always_comb begin
        full_d   = full_q;
        wr_idx_d = wr_idx_q;
        wb_d     = wb_q;
        if (accept) begin
            if (wr_idx_q == LAST_STEP) begin
                wr_idx_d       = '0;
                wb_d           = !wb_q;
                full_d[wb_q]   = 1'b1;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
        if (play_end) begin
            full_d[rb_q] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        hold_d  = hold_q;
        rb_d    = rb_q;
        case (state_q)
            IDLE: begin
                if (full_q[rb_q]) begin
                    state_d = PLAY;
                    step_d  = '0;
                    hold_d  = '0;
                end
            end
            PLAY: begin
                if (hold_q == LAST_HOLD) begin
                    hold_d = '0;
                    if (step_q == LAST_STEP) begin
                        step_d = '0;
                        rb_d   = !rb_q;
                        if (!full_q[!rb_q]) begin
                            state_d = IDLE;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output stage lags the FSM by one cycle; seq_done needs one more so it
    // lands after the final presented cycle rather than on it.
    always_comb begin
        x_valid_d  = (state_q == PLAY);
        first_d    = (state_q == PLAY) && (step_q == '0);
        last_d     = (state_q == PLAY) && (step_q == LAST_STEP);
        done_pre_d = play_end;
        done_d     = done_pre_q;
        if (state_q == PLAY) begin
            x_t_d = mem[rd_addr];
        end else begin
`ifdef GRU_FEED_HOLD_EN
            x_t_d = x_t_q;
`else
            x_t_d = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            full_q     <= '0;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            wr_idx_q   <= '0;
            step_q     <= '0;
            hold_q     <= '0;
            x_t_q      <= '0;
            x_valid_q  <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            done_pre_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            wr_idx_q   <= wr_idx_d;
            step_q     <= step_d;
            hold_q     <= hold_d;
            x_t_q      <= x_t_d;
            x_valid_q  <= x_valid_d;
            first_q    <= first_d;
            last_q     <= last_d;
            done_pre_q <= done_pre_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr] <= in_data;
        end
    end

    assign x_t       = x_t_q;
    assign x_valid   = x_valid_q;
    assign seq_first = first_q;
    assign seq_last  = last_q;
    assign seq_done  = done_q;

endmodule

// File: tb/tb_gru_seq_feeder.sv
// Directed bench for gru_seq_feeder: outputs are logged per cycle on the falling edge
// and compared against hand-derived playback timelines.
module tb_gru_seq_feeder;

    localparam int X = 6;
    localparam int L = 15;
    localparam int W = 16;
    localparam int S = 19;
    localparam int VW = X * W;
    localparam int SEQ_CYC = L * S;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_data;
    logic [VW-1:0] x_t;
    logic          x_valid, seq_first, seq_last, seq_done;

    gru_seq_feeder #(.X_SIZE(X), .SEQ_LEN(L), .WIDTH(W), .STEP_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .x_t(x_t), .x_valid(x_valid), .seq_first(seq_first),
        .seq_last(seq_last), .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [99:0] log_o   [0:8191];
    logic        log_rdy [0:8191];
    always @(negedge clk) begin
        if (cyc < 8192) begin
            log_o[cyc]   = {x_valid, seq_first, seq_last, seq_done, x_t};
            log_rdy[cyc] = in_ready;
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] vec(input int base, input int s, input bit spread);
        logic [VW-1:0] v;
        for (int e = 0; e < X; e++) v[e*W +: W] = W'(base + s + (spread ? e * 256 : 0));
        return v;
    endfunction

    function automatic logic [127:0] sig(input bit xv, input bit f, input bit l, input bit d,
                                         input logic [VW-1:0] xt);
        return {28'b0, xv, f, l, d, xt};
    endfunction

    function automatic logic [VW-1:0] idle_vec(input logic [VW-1:0] last);
`ifdef GRU_FEED_HOLD_EN
        return last;
`else
        return (last & '0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic send_beat(input logic [VW-1:0] d, output int acc);
        bit ok;
        in_valid = 1'b1;
        in_data  = d;
        for (int w = 0; w < 1000; w++) begin
            ok = in_ready;
            tick();
            if (ok) begin
                in_valid = 1'b0;
                acc = cyc;
                return;
            end
        end
        in_valid = 1'b0;
        acc = -1;
        chk("beat_timeout", 128'd0, 128'd1);
    endtask

    task automatic send_seq(input int base, input bit spread, input bit bursty,
                            output int first, output int last);
        int acc;
        first = -1;
        for (int s = 0; s < L; s++) begin
            if (bursty) repeat ((s * 5 + 1) % 3) tick();
            send_beat(vec(base, s, spread), acc);
            if (s == 0) first = acc;
        end
        last = acc;
    endtask

    task automatic play_check(input int start, input int base, input bit spread,
                              input bit done_first, input string tag);
        int f0;
        int s;
        wait_cyc(start + SEQ_CYC + 1);
        for (int k = 0; k < SEQ_CYC; k++) begin
            s = k / S;
            f0 = fails;
            chk(tag, {28'b0, log_o[start+k]},
                sig(1'b1, s == 0, s == L - 1, done_first && (k == 0), vec(base, s, spread)));
            if (fails != f0) break;
        end
    endtask

    task automatic done_check(input int c, input logic [VW-1:0] last, input string tag);
        wait_cyc(c + 2);
        chk(tag, {28'b0, log_o[c]}, sig(1'b0, 1'b0, 1'b0, 1'b1, idle_vec(last)));
        chk({tag, "_after"}, {28'b0, log_o[c+1]}, sig(1'b0, 1'b0, 1'b0, 1'b0, idle_vec(last)));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int f1, n1, f2, n2, f3, n3;
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) tick();
        chk("rst_out", sig(x_valid, seq_first, seq_last, seq_done, x_t), sig(0, 0, 0, 0, '0));
        chk("rst_ready", {127'b0, in_ready}, 128'd1);
        reset = 1'b0;
        tick();

        // Single sequence, uniform elements k+1
        send_seq(1, 1'b0, 1'b0, f1, n1);
        chk("single_load", n1 - f1, 14);
        wait_cyc(n1 + 3);
        chk("single_pre", {28'b0, log_o[n1+1]}, sig(0, 0, 0, 0, '0));
        play_check(n1 + 2, 1, 1'b0, 1'b0, "single_play");
        done_check(n1 + 2 + SEQ_CYC, vec(1, L - 1, 1'b0), "single_done");
        repeat (3) tick();

        // Back-to-back
        send_seq(16, 1'b1, 1'b0, f1, n1);
        send_seq(32, 1'b1, 1'b0, f2, n2);
        chk("b2b_contig", n2 - n1, 15);
        wait_cyc(n2 + 1);
        chk("b2b_rdy_before", {127'b0, log_rdy[n2-1]}, 128'd1);
        chk("b2b_rdy_full", {127'b0, log_rdy[n2]}, 128'd0);
        play_check(n1 + 2, 16, 1'b1, 1'b0, "b2b_play1");
        play_check(n1 + 2 + SEQ_CYC, 32, 1'b1, 1'b1, "b2b_play2");
        chk("b2b_rdy_held", {127'b0, log_rdy[n1+SEQ_CYC]}, 128'd0);
        chk("b2b_rdy_free", {127'b0, log_rdy[n1+1+SEQ_CYC]}, 128'd1);
        done_check(n1 + 2 + 2 * SEQ_CYC, vec(32, L - 1, 1'b1), "b2b_done");
        repeat (3) tick();

        // Backpressure: third sequence stalls until bank 0 frees
        send_seq(48, 1'b1, 1'b0, f1, n1);
        send_seq(64, 1'b1, 1'b0, f2, n2);
        send_seq(80, 1'b1, 1'b0, f3, n3);
        wait_cyc(n2 + 1);
        chk("bp_rdy_low", {127'b0, log_rdy[n2]}, 128'd0);
        chk("bp_resume", f3, n1 + 2 + SEQ_CYC);
        chk("bp_load3", n3 - f3, 14);
        play_check(n1 + 2, 48, 1'b1, 1'b0, "bp_play1");
        play_check(n1 + 2 + SEQ_CYC, 64, 1'b1, 1'b1, "bp_play2");
        play_check(n1 + 2 + 2 * SEQ_CYC, 80, 1'b1, 1'b1, "bp_play3");
        done_check(n1 + 2 + 3 * SEQ_CYC, vec(80, L - 1, 1'b1), "bp_done");
        repeat (3) tick();

        // Bursty upstream
        send_seq(96, 1'b1, 1'b1, f1, n1);
        play_check(n1 + 2, 96, 1'b1, 1'b0, "burst_play");
        done_check(n1 + 2 + SEQ_CYC, vec(96, L - 1, 1'b1), "burst_done");
        repeat (3) tick();

        // Reset during step 7
        send_seq(112, 1'b1, 1'b0, f1, n1);
        wait_cyc(n1 + 2 + 7 * S + 3);
        chk("mid_step7", {28'b0, log_o[n1+2+7*S+2]}, sig(1, 0, 0, 0, vec(112, 7, 1'b1)));
        reset = 1'b1;
        tick();
        chk("mid_rst_out", sig(x_valid, seq_first, seq_last, seq_done, x_t), sig(0, 0, 0, 0, '0));
        chk("mid_rst_ready", {127'b0, in_ready}, 128'd1);
        reset = 1'b0;
        tick();
        send_seq(128, 1'b1, 1'b0, f1, n1);
        play_check(n1 + 2, 128, 1'b1, 1'b0, "fresh_play");
        done_check(n1 + 2 + SEQ_CYC, vec(128, L - 1, 1'b1), "fresh_done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/gru_seq_feeder.md
# gru_seq_feeder

Input sequencer placed directly upstream of the GRU flavour-tagging core. It accepts track feature vectors over a valid/ready stream, one timestep per beat, and stores whole sequences in a ping-pong buffer. It then replays each sequence to the GRU cell one timestep at a time, holding each vector for the cell's fixed recurrence period. The next sequence can load while the current one is playing out.

## Interface
- X_SIZE, 6, features per timestep
- SEQ_LEN, 15, timesteps per sequence
- WIDTH, 16, signed fixed-point word width (NFRAC is irrelevant; data passes through untouched)
- STEP_CYCLES, 19, clock cycles each timestep is presented (GRU recurrence period)
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream beat valid
- in_ready  out  1  feeder can accept a beat
- in_data  in  WIDTH x [0:X_SIZE-1]  one timestep vector, signed
- x_t  out  WIDTH x [0:X_SIZE-1]  registered vector to the GRU cell
- x_valid  out  1  x_t holds a live timestep
- seq_first  out  1  high while step 0 is presented (GRU must clear h_t_minus_1)
- seq_last  out  1  high while step SEQ_LEN-1 is presented
- seq_done  out  1  one-cycle pulse after the last step's final cycle

## Operation
- Storage: two banks of SEQ_LEN x X_SIZE x WIDTH. Per-bank full flag. Write-bank pointer wb. Read-bank pointer rb.
- Loader:
  - in_ready = !full[wb], a combinational function of registers only.
  - A beat is accepted when in_valid && in_ready; it is written to bank[wb][wr_idx], then wr_idx increments.
  - On the beat with wr_idx==SEQ_LEN-1: set full[wb], clear wr_idx, toggle wb.
- Player FSM:
  - IDLE -> PLAY when full[rb].
  - In PLAY: hold_cnt counts 0..STEP_CYCLES-1 and step counts 0..SEQ_LEN-1.
  - x_t is registered from bank[rb][step].
  - When hold_cnt==STEP_CYCLES-1: hold_cnt clears and step increments.
  - At step==SEQ_LEN-1 with hold_cnt==STEP_CYCLES-1:
    - clear full[rb], toggle rb, pulse seq_done on the next cycle.
    - If full[!rb], stay in PLAY with step=0, giving zero-gap back-to-back playback. Otherwise go to IDLE.
- Outputs:
  - x_valid=1 exactly while in PLAY.
  - seq_first = PLAY && step==0.
  - seq_last = PLAY && step==SEQ_LEN-1.
- Simultaneous events:
  - Loading bank[wb] while bank[rb] plays is always legal.
  - Freeing a bank and accepting a beat into the other bank in the same cycle are independent.
  - A bank freed on cycle n has in_ready visible at n+1.
- Both banks full: in_ready=0. Upstream stalls; no data is lost or overwritten.
- Reset, including mid-load or mid-play:
  - All full flags, pointers and counters clear; FSM goes to IDLE.
  - Partial sequences are discarded. Bank contents need no clearing.

## Timing
- Reset values: in_ready=1, x_t all 0, x_valid=0, seq_first=0, seq_last=0, seq_done=0.
- Load-to-play latency:
  - The final beat of a sequence is accepted at edge n, so full is set at n.
  - The FSM enters PLAY at n+1.
  - x_t carries step 0 with x_valid=1 from n+2.
- Each step is presented for exactly STEP_CYCLES consecutive cycles.
- A sequence occupies SEQ_LEN*STEP_CYCLES cycles (285 at defaults).
- seq_done is asserted in the first cycle after the last x_valid cycle of a sequence, for one cycle. With back-to-back play, it coincides with step 0 of the next sequence.
- Throughput: the loader accepts one beat per cycle. Upstream must not expect to sustain more than one sequence per SEQ_LEN*STEP_CYCLES cycles.

## Configuration
- GRU_FEED_HOLD_EN:
  - Defined: while IDLE, x_t retains the last presented vector, which reduces toggling into the GRU MAC array.
  - Undefined: x_t is forced to all zeros whenever the FSM is IDLE, including the cycle IDLE is entered.
- x_valid, seq_first and seq_last behave identically either way.

## Test plan
- Single sequence: after reset, stream 15 beats on consecutive cycles where beat k has every element = k+1 -> x_t = {1,...} from cycle n+2 for 19 cycles, then 2, ... up to 15. seq_first is high for the first 19 cycles and seq_last for the last 19. seq_done pulses once at n+2+285.
- Back-to-back: load two sequences (values 0x0010.., 0x0020..) without gaps -> second playback starts the cycle after the first's last step. seq_done coincides with seq_first. in_ready drops after 30 beats.
- Backpressure: load three sequences continuously -> in_ready=0 after beat 30. It reasserts the cycle after the first seq_done-causing edge. The third sequence plays intact with no lost or duplicated beats.
- Bursty input: in_valid toggling 1/0 with random gaps -> playback content identical to the gapless case. Start is n+2 after the 15th accepted beat.
- Reset mid-play: assert reset at step 7 -> next cycle all outputs are at reset values and in_ready=1. A fresh sequence then plays from step 0.
- Macro check: run the single-sequence test with and without GRU_FEED_HOLD_EN -> after seq_done, x_t holds 15 in each element when defined, and is 0 when undefined.
